// File: rtl/latch_bank_writer_pkg.sv
// Shared types and helpers for the latch bank write sequencer.
package latch_bank_writer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    CLR,
    RECOV
  } state_t;

  localparam int CW        = 4;
  localparam int MAX_WORDS = 1024;

  // Out-of-range addresses return all zeros, so no row is ever enabled for them.
  function automatic logic [MAX_WORDS-1:0] onehot(input logic [31:0] addr, input int words);
    onehot = '0;
    if (addr < $unsigned(words)) onehot[addr[9:0]] = 1'b1;
  endfunction

endpackage

// File: rtl/latch_bank_writer_timer.sv
// Loadable down-counter; done is high during the last cycle of a loaded duration.
module latch_bank_writer_timer
  import latch_bank_writer_pkg::*;
(
  input  logic          CLK,
  input  logic          RN,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  assign done = (cnt_reg == CW'(1));

endmodule

// File: rtl/latch_bank_writer.sv
// Write sequencer for a bank of transparent latches: setup, enable pulse, hold,
// and bank clear, with every latch-facing output driven straight from a flop.
module latch_bank_writer
  import latch_bank_writer_pkg::*;
#(
  parameter int WORDS     = 8,
  parameter int WIDTH     = 8,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1,
  localparam int AW       = $clog2(WORDS)
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_data,
  input  logic             clr_req,
  output logic [WIDTH-1:0] lat_D,
  output logic [WORDS-1:0] lat_E,
  output logic             lat_RN,
  output logic             err
);

  state_t           state_reg, state_next;
  logic [AW-1:0]    addr_reg, addr_next;
  logic [WIDTH-1:0] lat_d_reg, lat_d_next;
  logic [WORDS-1:0] lat_e_reg, lat_e_next;
  logic             lat_rn_reg, lat_rn_next;
  logic             ready_reg, ready_next;
  logic             err_reg, err_next;
  logic             timer_load;
  logic [CW-1:0]    timer_val;
  logic             timer_done;
  logic [WORDS-1:0] row_sel;

  assign row_sel = WORDS'(onehot(32'(addr_reg), WORDS));

  latch_bank_writer_timer u_timer (
    .CLK      (CLK),
    .RN       (RN),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    lat_d_next  = lat_d_reg;
    lat_e_next  = '0;
    lat_rn_next = 1'b1;
    ready_next  = 1'b0;
    err_next    = 1'b0;
    timer_load  = 1'b0;
    timer_val   = '0;
    case (state_reg)
      IDLE: begin
        // ready_reg gates acceptance so nothing is taken on the first edge after reset
        if (ready_reg && clr_req) begin
          state_next  = CLR;
          lat_rn_next = 1'b0;
          timer_load  = 1'b1;
          timer_val   = CW'(PULSE_CYC);
        end else if (ready_reg && req_valid) begin
          state_next = SETUP;
          addr_next  = req_addr;
          lat_d_next = req_data;
          err_next   = (32'(req_addr) >= 32'(WORDS));
        end else begin
          ready_next = 1'b1;
        end
      end
      SETUP: begin
        state_next = PULSE;
        lat_e_next = row_sel;
        timer_load = 1'b1;
        timer_val  = CW'(PULSE_CYC);
      end
      PULSE: begin
        if (timer_done) begin
          state_next = HOLD;
          timer_load = 1'b1;
          timer_val  = CW'(HOLD_CYC);
        end else begin
          lat_e_next = row_sel;
        end
      end
      HOLD: begin
        if (timer_done) begin
          state_next = IDLE;
          ready_next = 1'b1;
        end
      end
      CLR: begin
        if (timer_done) state_next = RECOV;
        else            lat_rn_next = 1'b0;
      end
      RECOV: begin
        state_next = IDLE;
        ready_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      lat_d_reg  <= '0;
      lat_e_reg  <= '0;
      lat_rn_reg <= 1'b0;
      ready_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      lat_d_reg  <= lat_d_next;
      lat_e_reg  <= lat_e_next;
      lat_rn_reg <= lat_rn_next;
      ready_reg  <= ready_next;
      err_reg    <= err_next;
    end
  end

  assign req_ready = ready_reg;
  assign lat_D     = lat_d_reg;
  assign lat_E     = lat_e_reg;
  assign lat_RN    = lat_rn_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_latch_bank_writer.sv
// Directed bench: three sequencer instances (defaults, PULSE_CYC=3, WORDS=6) with latch models.
module tb_latch_bank_writer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // instance a: defaults
  logic       rn_a, valid_a, ready_a, clr_a, lat_rn_a, err_a;
  logic [2:0] addr_a;
  logic [7:0] data_a, lat_d_a, lat_e_a;
  // instance b: PULSE_CYC=3
  logic       rn_b, valid_b, ready_b, clr_b, lat_rn_b, err_b;
  logic [2:0] addr_b;
  logic [7:0] data_b, lat_d_b, lat_e_b;
  // instance c: WORDS=6
  logic       rn_c, valid_c, ready_c, clr_c, lat_rn_c, err_c;
  logic [2:0] addr_c;
  logic [7:0] data_c, lat_d_c;
  logic [5:0] lat_e_c;

  logic [7:0] mem_a [8];
  logic [7:0] mem_b [8];

  latch_bank_writer dut_a (
    .CLK(CLK), .RN(rn_a), .req_valid(valid_a), .req_ready(ready_a), .req_addr(addr_a),
    .req_data(data_a), .clr_req(clr_a), .lat_D(lat_d_a), .lat_E(lat_e_a),
    .lat_RN(lat_rn_a), .err(err_a)
  );

  latch_bank_writer #(.PULSE_CYC(3)) dut_b (
    .CLK(CLK), .RN(rn_b), .req_valid(valid_b), .req_ready(ready_b), .req_addr(addr_b),
    .req_data(data_b), .clr_req(clr_b), .lat_D(lat_d_b), .lat_E(lat_e_b),
    .lat_RN(lat_rn_b), .err(err_b)
  );

  latch_bank_writer #(.WORDS(6)) dut_c (
    .CLK(CLK), .RN(rn_c), .req_valid(valid_c), .req_ready(ready_c), .req_addr(addr_c),
    .req_data(data_c), .clr_req(clr_c), .lat_D(lat_d_c), .lat_E(lat_e_c),
    .lat_RN(lat_rn_c), .err(err_c)
  );

  // Behavioural latch arrays: reset dominant, transparent while enabled.
  always @(lat_e_a or lat_d_a or lat_rn_a)
    for (int r = 0; r < 8; r++)
      if (lat_rn_a === 1'b0) mem_a[r] = 8'h00;
      else if (lat_e_a[r] === 1'b1) mem_a[r] = lat_d_a;

  always @(lat_e_b or lat_d_b or lat_rn_b)
    for (int r = 0; r < 8; r++)
      if (lat_rn_b === 1'b0) mem_b[r] = 8'h00;
      else if (lat_e_b[r] === 1'b1) mem_b[r] = lat_d_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rn_a = 0; rn_b = 0; rn_c = 0;
    valid_a = 0; valid_b = 0; valid_c = 0;
    clr_a = 0; clr_b = 0; clr_c = 0;
    addr_a = 0; addr_b = 0; addr_c = 0;
    data_a = 0; data_b = 0; data_c = 0;

    // reset
    tick; tick;
    chk("rst_lat_rn", 32'(lat_rn_a), 0);
    chk("rst_lat_e", 32'(lat_e_a), 0);
    chk("rst_ready", 32'(ready_a), 0);
    chk("rst_lat_d", 32'(lat_d_a), 0);
    chk("rst_err", 32'(err_a), 0);
    rn_a = 1; rn_b = 1; rn_c = 1;
    tick;
    chk("rel_lat_rn", 32'(lat_rn_a), 1);
    chk("rel_ready", 32'(ready_a), 1);
    chk("rel_ready_b", 32'(ready_b), 1);
    chk("rel_ready_c", 32'(ready_c), 1);

    // single write addr 3 data A5
    valid_a = 1; addr_a = 3; data_a = 8'hA5;
    tick; // edge 0
    valid_a = 0;
    chk("w0_lat_d", 32'(lat_d_a), 32'hA5);
    chk("w0_lat_e", 32'(lat_e_a), 0);
    chk("w0_ready", 32'(ready_a), 0);
    chk("w0_err", 32'(err_a), 0);
    tick; // edge 1
    chk("w1_lat_e", 32'(lat_e_a), 32'h08);
    chk("w1_lat_d", 32'(lat_d_a), 32'hA5);
    tick; // edge 2
    chk("w2_lat_e", 32'(lat_e_a), 0);
    chk("w2_ready", 32'(ready_a), 0);
    chk("w2_lat_d", 32'(lat_d_a), 32'hA5);
    tick; // edge 3
    chk("w3_ready", 32'(ready_a), 1);
    chk("w3_row3", 32'(mem_a[3]), 32'hA5);

    // back-to-back: addr 0 then 7, valid held
    valid_a = 1; addr_a = 0; data_a = 8'h3C;
    tick; // b0
    addr_a = 7; data_a = 8'hC3;
    chk("b0_lat_d", 32'(lat_d_a), 32'h3C);
    chk("b0_ready", 32'(ready_a), 0);
    tick; // b1
    chk("b1_lat_e", 32'(lat_e_a), 32'h01);
    chk("b1_lat_d", 32'(lat_d_a), 32'h3C);
    tick; // b2
    chk("b2_lat_e", 32'(lat_e_a), 0);
    chk("b2_lat_d", 32'(lat_d_a), 32'h3C);
    tick; // b3
    chk("b3_ready", 32'(ready_a), 1);
    chk("b3_lat_d", 32'(lat_d_a), 32'h3C);
    tick; // b4: second accept
    valid_a = 0;
    chk("b4_lat_d", 32'(lat_d_a), 32'hC3);
    chk("b4_lat_e", 32'(lat_e_a), 0);
    chk("b4_ready", 32'(ready_a), 0);
    tick; // b5
    chk("b5_lat_e", 32'(lat_e_a), 32'h80);
    chk("b5_lat_d", 32'(lat_d_a), 32'hC3);
    tick; // b6
    chk("b6_lat_e", 32'(lat_e_a), 0);
    chk("b6_lat_d", 32'(lat_d_a), 32'hC3);
    tick; // b7
    chk("b7_ready", 32'(ready_a), 1);
    chk("b7_row0", 32'(mem_a[0]), 32'h3C);
    chk("b7_row7", 32'(mem_a[7]), 32'hC3);
    chk("b7_row3", 32'(mem_a[3]), 32'hA5);

    // reset asserted during PULSE
    valid_a = 1; addr_a = 5; data_a = 8'h5A;
    tick; // r0
    valid_a = 0;
    tick; // r1
    chk("r1_lat_e", 32'(lat_e_a), 32'h20);
    #2 rn_a = 0;
    #1;
    chk("r_async_lat_e", 32'(lat_e_a), 0);
    chk("r_async_lat_rn", 32'(lat_rn_a), 0);
    chk("r_async_ready", 32'(ready_a), 0);
    chk("r_async_row5", 32'(mem_a[5]), 0);
    #2 rn_a = 1;
    tick;
    chk("r_rel_ready", 32'(ready_a), 1);
    chk("r_rel_lat_rn", 32'(lat_rn_a), 1);
    valid_a = 1; addr_a = 2; data_a = 8'h99;
    tick;
    valid_a = 0;
    chk("r_w0_lat_d", 32'(lat_d_a), 32'h99);
    tick;
    chk("r_w1_lat_e", 32'(lat_e_a), 32'h04);
    tick;
    tick;
    chk("r_w3_ready", 32'(ready_a), 1);
    chk("r_w3_row2", 32'(mem_a[2]), 32'h99);

    // instance b: write row 1, then clear+write together
    valid_b = 1; addr_b = 1; data_b = 8'h77;
    tick; // c0
    valid_b = 0;
    tick; // c1
    chk("c1_lat_e", 32'(lat_e_b), 32'h02);
    tick; tick; // c3
    chk("c3_lat_e", 32'(lat_e_b), 32'h02);
    tick; // c4
    chk("c4_lat_e", 32'(lat_e_b), 0);
    tick; // c5
    chk("c5_ready", 32'(ready_b), 1);
    chk("c5_row1", 32'(mem_b[1]), 32'h77);
    clr_b = 1; valid_b = 1; addr_b = 4; data_b = 8'hE1;
    tick; // d0
    clr_b = 0;
    chk("d0_lat_rn", 32'(lat_rn_b), 0);
    chk("d0_ready", 32'(ready_b), 0);
    chk("d0_lat_d", 32'(lat_d_b), 32'h77);
    tick; tick; // d2
    chk("d2_lat_rn", 32'(lat_rn_b), 0);
    chk("d2_lat_e", 32'(lat_e_b), 0);
    tick; // d3
    chk("d3_lat_rn", 32'(lat_rn_b), 1);
    chk("d3_ready", 32'(ready_b), 0);
    tick; // d4
    chk("d4_ready", 32'(ready_b), 1);
    chk("d4_lat_d", 32'(lat_d_b), 32'h77);
    chk("d4_row1", 32'(mem_b[1]), 0);
    chk("d4_row4", 32'(mem_b[4]), 0);
    tick; // d5: write accepted
    valid_b = 0;
    chk("d5_lat_d", 32'(lat_d_b), 32'hE1);
    chk("d5_ready", 32'(ready_b), 0);
    tick; // d6
    chk("d6_lat_e", 32'(lat_e_b), 32'h10);
    tick; tick; tick; // d9
    chk("d9_lat_e", 32'(lat_e_b), 0);
    tick; // d10
    chk("d10_ready", 32'(ready_b), 1);
    chk("d10_row4", 32'(mem_b[4]), 32'hE1);

    // instance c: out-of-range address 6
    valid_c = 1; addr_c = 6; data_c = 8'h42;
    tick; // e0
    valid_c = 0;
    chk("e0_err", 32'(err_c), 1);
    chk("e0_lat_d", 32'(lat_d_c), 32'h42);
    chk("e0_ready", 32'(ready_c), 0);
    tick; // e1
    chk("e1_err", 32'(err_c), 0);
    chk("e1_lat_e", 32'(lat_e_c), 0);
    tick; // e2
    chk("e2_lat_e", 32'(lat_e_c), 0);
    chk("e2_ready", 32'(ready_c), 0);
    tick; // e3
    chk("e3_ready", 32'(ready_c), 1);
    chk("e3_err", 32'(err_c), 0);
    // in-range write on the 6-row instance still enables its row
    valid_c = 1; addr_c = 5; data_c = 8'h24;
    tick;
    valid_c = 0;
    chk("f0_err", 32'(err_c), 0);
    tick;
    chk("f1_lat_e", 32'(lat_e_c), 32'h20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
